// File: rtl/sumsq_pkg.sv
// Shared widths and state encoding for the sum-of-squares engine.
package sumsq_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } sumsq_st_e;

    function automatic int sum_w(input int in_w, input int n_ch);
        return 2 * in_w - 1 + $clog2(n_ch);
    endfunction

    function automatic int acc_w(input int in_w, input int n_ch, input int cnt_w);
        return sum_w(in_w, n_ch) + cnt_w;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sumsq_adder_tree.sv
// S1 registered per-channel squares and S2 registered balanced adder tree.
module sumsq_adder_tree
    import sumsq_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int IN_W = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             en,
    input  logic                             in_valid,
    input  logic [N_CH*IN_W-1:0]             in_data,
    output logic                             out_valid,
    output logic [sum_w(IN_W, N_CH)-1:0]     out_sum
);

    localparam int SQ_W  = 2 * IN_W - 1;
    localparam int SUM_W = sum_w(IN_W, N_CH);
    localparam int NP    = 1 << $clog2(N_CH);

    logic signed [IN_W-1:0]  smp  [N_CH];
    logic        [SQ_W-1:0]  sq_d [N_CH];
    logic        [SQ_W-1:0]  sq_q [N_CH];
    logic        [SUM_W-1:0] node [2*NP];
    logic                    v1_q;

    // Low SQ_W bits of the product are exact: the square always fits in SQ_W bits.
    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            smp[k]  = in_data[k*IN_W +: IN_W];
            sq_d[k] = SQ_W'(smp[k] * smp[k]);
        end
    end

    // Heap-ordered tree: leaves at NP..2*NP-1, root at node[1], missing leaves zero.
    always_comb begin
        for (int unsigned i = 0; i < 2 * NP; i++) begin
            node[i] = '0;
        end
        for (int unsigned k = 0; k < N_CH; k++) begin
            node[NP+k] = SUM_W'(sq_q[k]);
        end
        for (int unsigned j = 1; j < NP; j++) begin
            node[NP-j] = node[2*(NP-j)] + node[2*(NP-j)+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1_q      <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1_q      <= in_valid;
            out_valid <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                sq_q[k] <= sq_d[k];
            end
            out_sum <= node[1];
        end
    end

endmodule

// File: rtl/sumsq_acc_pipe.sv
// Multi-channel signed sum-of-squares engine with PASS / windowed ACC modes and output saturation.
module sumsq_acc_pipe
    import sumsq_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int IN_W  = 16,
    parameter int CNT_W = 8,
    parameter int OUT_W = 40
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CH*IN_W-1:0] in_data,
    input  logic                 mode_acc,
    input  logic [CNT_W-1:0]     win_len,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_sat,
    output logic                 out_last
);

    localparam int SUM_W = sum_w(IN_W, N_CH);
    localparam int ACC_W = acc_w(IN_W, N_CH, CNT_W);
    localparam int EXT_W = max_i(ACC_W, OUT_W) + 1;

    logic              adv;
    logic              s2_valid;
    logic [SUM_W-1:0]  s2_sum;

    sumsq_st_e         st_q, st_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  win_eff;
    logic [ACC_W-1:0]  s_ext;
    logic [ACC_W-1:0]  res;
    logic [EXT_W-1:0]  res_ext;
    logic              emit;
    logic              sat;
    logic [OUT_W-1:0]  data_d;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    sumsq_adder_tree #(
        .N_CH (N_CH),
        .IN_W (IN_W)
    ) u_tree (
        .clk       (clk),
        .rstn      (rstn),
        .en        (adv),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (s2_valid),
        .out_sum   (s2_sum)
    );

    always_comb begin
        st_d    = st_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        emit    = 1'b0;
        res     = '0;
        win_eff = (win_len == '0) ? CNT_W'(1) : win_len;
        s_ext   = ACC_W'(s2_sum);
        if (s2_valid) begin
            unique case (st_q)
                IDLE: begin
                    if (!mode_acc || win_eff == CNT_W'(1)) begin
                        emit = 1'b1;
                        res  = s_ext;
                    end else begin
                        acc_d = s_ext;
                        cnt_d = CNT_W'(1);
                        len_d = win_eff;
                        st_d  = RUN;
                    end
                end
                RUN: begin
                    if (cnt_q + CNT_W'(1) == len_q) begin
                        emit  = 1'b1;
                        res   = acc_q + s_ext;
                        acc_d = '0;
                        cnt_d = '0;
                        st_d  = IDLE;
                    end else begin
                        acc_d = acc_q + s_ext;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    // Anything at or above bit OUT_W means the result exceeds 2**OUT_W-1.
    always_comb begin
        res_ext = EXT_W'(res);
        sat     = |(res_ext >> OUT_W);
        data_d  = sat ? '1 : res_ext[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_q      <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_last  <= 1'b0;
        end else if (adv) begin
            st_q      <= st_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            out_valid <= emit;
            if (emit) begin
                out_data <= data_d;
                out_sat  <= sat;
                out_last <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sumsq_acc_pipe.sv
// Scoreboard bench for sumsq_acc_pipe: default build plus an OUT_W=31 build fed identically.
module tb_sumsq_acc_pipe;

    localparam int N_CH   = 2;
    localparam int IN_W   = 16;
    localparam int CNT_W  = 8;
    localparam int OUT_W  = 40;
    localparam int OUT_WN = 31;
    localparam longint MAX40 = (longint'(1) << OUT_W) - 1;
    localparam longint MAX31 = (longint'(1) << OUT_WN) - 1;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 in_valid = 1'b0;
    logic [N_CH*IN_W-1:0] in_data = '0;
    logic                 mode_acc = 1'b0;
    logic [CNT_W-1:0]     win_len = '0;
    logic                 out_ready = 1'b1;

    logic                 in_ready, out_valid, out_sat, out_last;
    logic [OUT_W-1:0]     out_data;
    logic                 in_ready_n, out_valid_n, out_sat_n, out_last_n;
    logic [OUT_WN-1:0]    out_data_n;

    always #5 clk = ~clk;

    sumsq_acc_pipe #(.N_CH(N_CH), .IN_W(IN_W), .CNT_W(CNT_W), .OUT_W(OUT_W)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mode_acc(mode_acc), .win_len(win_len), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_last(out_last)
    );

    sumsq_acc_pipe #(.N_CH(N_CH), .IN_W(IN_W), .CNT_W(CNT_W), .OUT_W(OUT_WN)) u_dut_n (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
        .mode_acc(mode_acc), .win_len(win_len), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_data(out_data_n), .out_sat(out_sat_n), .out_last(out_last_n)
    );

    typedef struct {
        longint val;
        int     cyc;
        bit     lat;
    } exp_t;

    exp_t   q[$];
    exp_t   qn[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     n_out = 0;
    bit     lat_en = 1'b0;
    bit     stop_rnd = 1'b0;

    bit     m_run = 1'b0;
    longint m_acc = 0;
    int     m_cnt = 0;
    int     m_len = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input longint v);
        exp_t e;
        e.val = v;
        e.cyc = cyc;
        e.lat = lat_en;
        q.push_back(e);
        qn.push_back(e);
    endtask

    task automatic model_beat(input int a, input int b);
        longint e;
        int     len;
        e = longint'(a) * a + longint'(b) * b;
        if (!m_run) begin
            len = (win_len == 0) ? 1 : int'(win_len);
            if (!mode_acc || len == 1) begin
                push_exp(e);
            end else begin
                m_acc = e;
                m_cnt = 1;
                m_len = len;
                m_run = 1'b1;
            end
        end else if (m_cnt + 1 == m_len) begin
            push_exp(m_acc + e);
            m_run = 1'b0;
            m_acc = 0;
            m_cnt = 0;
        end else begin
            m_acc += e;
            m_cnt++;
        end
    endtask

    task automatic send(input int a, input int b);
        int w;
        bit ok;
        w  = 0;
        ok = 1'b0;
        in_data  = {b[IN_W-1:0], a[IN_W-1:0]};
        in_valid = 1'b1;
        while (!ok && w < 200) begin
            @(negedge clk);
            if (in_ready && in_ready_n) ok = 1'b1;
            else w++;
        end
        if (ok) model_beat(a, b);
        else check("send_timeout", 64'(w), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((q.size() != 0 || qn.size() != 0) && w < 300) begin
            @(posedge clk);
            w++;
        end
        if (w >= 300) check("drain_timeout", 64'(q.size() + qn.size()), 64'(0));
        idle(3);
    endtask

    // Default-width monitor: data, flags, latency and stall stability.
    logic             stall = 1'b0;
    logic [OUT_W-1:0] held = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            stall = 1'b0;
        end else begin
            if (stall) check("stall_hold", 64'(out_data), 64'(held));
            if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'(0));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("out_without_expect", 64'(out_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    check("data", 64'(out_data), 64'((e.val > MAX40) ? MAX40 : e.val));
                    check("sat", 64'(out_sat), 64'(e.val > MAX40));
                    check("last", 64'(out_last), 64'(1));
                    if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(3));
                    n_out++;
                end
            end
            stall = out_valid && !out_ready;
            held  = out_data;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rstn && out_valid_n && out_ready) begin
            if (qn.size() == 0) begin
                check("out31_without_expect", 64'(out_valid_n), 64'(0));
            end else begin
                e = qn.pop_front();
                check("data31", 64'(out_data_n), 64'((e.val > MAX31) ? MAX31 : e.val));
                check("sat31", 64'(out_sat_n), 64'(e.val > MAX31));
                check("last31", 64'(out_last_n), 64'(1));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n0;
        int a;
        int b;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_sat", 64'(out_sat), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid31", 64'(out_valid_n), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);

        // PASS, back-to-back, fixed latency
        mode_acc = 1'b0;
        lat_en   = 1'b1;
        n0 = n_out;
        send(3, 4);
        send(-5, 12);
        wait_idle();
        check("pass_count", 64'(n_out - n0), 64'(2));

        // Extremes: 2**31 exact at 40 bits, saturated at 31 bits; just-below stays exact
        n0 = n_out;
        send(-32768, -32768);
        send(32767, -32768);
        send(-32768, 0);
        wait_idle();
        lat_en = 1'b0;
        check("extreme_count", 64'(n_out - n0), 64'(3));

        // Backpressure: out_ready low for four cycles mid-stream
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(i, 0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_idle();
        check("bp_count", 64'(n_out - n0), 64'(8));

        // ACC window of 4 with bubbles
        mode_acc = 1'b1;
        win_len  = 8'd4;
        n0 = n_out;
        send(1, 1);
        idle(2);
        send(2, 0);
        idle(3);
        send(0, 3);
        idle(1);
        send(1, 2);
        wait_idle();
        check("acc4_count", 64'(n_out - n0), 64'(1));

        // win_len 0 behaves as 1
        win_len = 8'd0;
        n0 = n_out;
        send(5, 0);
        send(0, 7);
        send(1, 1);
        wait_idle();
        check("len0_count", 64'(n_out - n0), 64'(3));

        // Reset in the middle of a window discards it
        win_len = 8'd4;
        send(1, 1);
        send(2, 2);
        idle(4);
        check("sb_empty_at_reset", 64'(q.size()), 64'(0));
        rstn  = 1'b0;
        m_run = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        @(negedge clk);
        check("rst_mid_valid_during", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_mid_valid_after", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        n0 = n_out;
        for (int i = 0; i < 4; i++) send(1, 0);
        wait_idle();
        check("rst_mid_count", 64'(n_out - n0), 64'(1));

        // Mode and length changes during RUN are ignored until the window closes
        win_len = 8'd3;
        n0 = n_out;
        send(2, 0);
        idle(2);
        send(3, 0);
        idle(4);
        mode_acc = 1'b0;
        win_len  = 8'd7;
        send(1, 0);
        idle(2);
        send(4, 0);
        send(0, 2);
        wait_idle();
        check("modechg_count", 64'(n_out - n0), 64'(3));

        // Random ACC stream under random backpressure
        mode_acc = 1'b1;
        win_len  = 8'd3;
        n0 = n_out;
        stop_rnd = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    a = int'($urandom_range(0, 65535)) - 32768;
                    b = int'($urandom_range(0, 65535)) - 32768;
                    send(a, b);
                    idle(int'($urandom_range(0, 2)));
                end
                stop_rnd = 1'b1;
            end
            begin
                while (!stop_rnd) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();
        check("rnd_count", 64'(n_out - n0), 64'(10));

        check("sb_leftover", 64'(q.size() + qn.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
